// File: rtl/alu_issue_stage_pkg.sv
// Shared RV32I types for the ALU issue path: ALU operation codes, operand
// select encodings and the entry stored in the issue stage's skid buffer.
package rv32i_types;

  typedef enum logic [3:0] {
    alu_add  = 4'd0,
    alu_sub  = 4'd1,
    alu_sll  = 4'd2,
    alu_slt  = 4'd3,
    alu_sltu = 4'd4,
    alu_xor  = 4'd5,
    alu_srl  = 4'd6,
    alu_sra  = 4'd7,
    alu_or   = 4'd8,
    alu_and  = 4'd9
  } alu_ops;

  typedef enum logic {
    ASEL_RS1 = 1'b0,
    ASEL_PC  = 1'b1
  } asel_t;

  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } bsel_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    asel_t       asel;
    bsel_t       bsel;
    alu_ops      aluop;
    logic [4:0]  rd;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_stage_fwd_match.sv
// fwd_match: resolves one source operand against the forwarding ports.
// Port 0 is the youngest producer, so the lowest matching index wins.
// Register x0 never matches and keeps its current value.
module fwd_match #(
  parameter int NUM_FWD = 2
) (
  input  logic [4:0]           idx,
  input  logic [31:0]          cur_val,
  input  logic [NUM_FWD-1:0]   fwd_valid,
  input  logic [NUM_FWD*5-1:0] fwd_rd,
  input  logic [NUM_FWD*32-1:0] fwd_data,
  output logic [31:0]          res_val
);

  // Scan from oldest to youngest so the youngest match overwrites last.
  always_comb begin
    res_val = cur_val;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if ((idx != 5'd0) && fwd_valid[i] && (fwd_rd[i*5 +: 5] == idx)) begin
        res_val = fwd_data[i*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-entry skid buffer in front of the ALU. MAIN drives the
// ALU operands, SKID absorbs one extra instruction so in_ready can be a flop.
// Operands are resolved against the forwarding ports on capture and every
// cycle while held. Optional macro ALU_ISSUE_STATS_EN adds issue/stall
// counters (stat_issued, stat_stall).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that interface; valid never depends on ready, and in_ready is taken
// straight from a flop (!SKID.valid) so out_ready never reaches it.
module alu_issue_stage
  import rv32i_types::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [4:0]            in_rs1_idx,
  input  logic [4:0]            in_rs2_idx,
  input  logic [31:0]           in_rs1_data,
  input  logic [31:0]           in_rs2_data,
  input  logic [31:0]           in_imm,
  input  logic                  in_asel,
  input  logic                  in_bsel,
  input  alu_ops                in_aluop,
  input  logic [4:0]            in_rd,
  input  logic [NUM_FWD-1:0]    fwd_valid,
  input  logic [NUM_FWD*5-1:0]  fwd_rd,
  input  logic [NUM_FWD*32-1:0] fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output alu_ops                out_aluop,
  output logic [31:0]           out_a,
  output logic [31:0]           out_b,
  output logic [4:0]            out_rd,
  output logic [31:0]           out_pc
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  issue_entry_t main_q, main_d, skid_q, skid_d;
  issue_entry_t inc_raw, main_src, skid_src;
  logic [31:0]  main_rs1_res, main_rs2_res, skid_rs1_res, skid_rs2_res;
  logic         accept, issue, main_free;
  logic         main_load_skid, main_load_in, skid_load_in;

  assign in_ready  = !skid_q.valid;
  assign out_valid = main_q.valid;
  assign accept    = in_valid && in_ready;
  assign issue     = main_q.valid && out_ready;
  assign main_free = !main_q.valid || issue;

  assign main_load_skid = main_free && skid_q.valid;
  assign main_load_in   = main_free && !skid_q.valid && accept;
  assign skid_load_in   = accept && !main_free;

  // Incoming instruction with register-file data, before forwarding.
  always_comb begin
    inc_raw         = '0;
    inc_raw.valid   = 1'b1;
    inc_raw.pc      = in_pc;
    inc_raw.rs1_idx = in_rs1_idx;
    inc_raw.rs2_idx = in_rs2_idx;
    inc_raw.rs1_val = in_rs1_data;
    inc_raw.rs2_val = in_rs2_data;
    inc_raw.imm     = in_imm;
    inc_raw.asel    = asel_t'(in_asel);
    inc_raw.bsel    = bsel_t'(in_bsel);
    inc_raw.aluop   = in_aluop;
    inc_raw.rd      = in_rd;
  end

  // Pick what each entry holds next; forwarding is applied after the mux so
  // captured, held and SKID->MAIN moves all see this cycle's producers.
  always_comb begin
    main_src = main_q;
    if (main_load_skid) begin
      main_src = skid_q;
    end else if (main_load_in) begin
      main_src = inc_raw;
    end
    skid_src = skid_load_in ? inc_raw : skid_q;
  end

  fwd_match #(.NUM_FWD(NUM_FWD)) u_fwd_main_rs1 (
    .idx(main_src.rs1_idx), .cur_val(main_src.rs1_val), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res_val(main_rs1_res)
  );
  fwd_match #(.NUM_FWD(NUM_FWD)) u_fwd_main_rs2 (
    .idx(main_src.rs2_idx), .cur_val(main_src.rs2_val), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res_val(main_rs2_res)
  );
  fwd_match #(.NUM_FWD(NUM_FWD)) u_fwd_skid_rs1 (
    .idx(skid_src.rs1_idx), .cur_val(skid_src.rs1_val), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res_val(skid_rs1_res)
  );
  fwd_match #(.NUM_FWD(NUM_FWD)) u_fwd_skid_rs2 (
    .idx(skid_src.rs2_idx), .cur_val(skid_src.rs2_val), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .res_val(skid_rs2_res)
  );

  // Next-state of both entries: occupancy bookkeeping plus flush.
  always_comb begin
    main_d         = main_src;
    main_d.rs1_val = main_rs1_res;
    main_d.rs2_val = main_rs2_res;
    main_d.valid   = main_load_skid || main_load_in || (main_q.valid && !issue);
    skid_d         = skid_src;
    skid_d.rs1_val = skid_rs1_res;
    skid_d.rs2_val = skid_rs2_res;
    skid_d.valid   = skid_load_in || (skid_q.valid && !main_load_skid);
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end
  end

  // Entry registers; reset zeroes the payload too so outputs are never X.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // ALU operand mux, driven only from MAIN.
  always_comb begin
    out_aluop = main_q.aluop;
    out_rd    = main_q.rd;
    out_pc    = main_q.pc;
    out_a     = (main_q.asel == ASEL_PC)  ? main_q.pc  : main_q.rs1_val;
    out_b     = (main_q.bsel == BSEL_IMM) ? main_q.imm : main_q.rs2_val;
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_stall_q, stat_stall_d;

  // Counters wrap naturally; flush leaves them alone.
  always_comb begin
    stat_issued_d = stat_issued_q + {31'd0, issue};
    stat_stall_d  = stat_stall_q + {31'd0, (main_q.valid && !out_ready)};
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, single issue, back-pressure
// ordering, forwarding at capture and while stalled, x0, flush, reset+flush,
// and the optional statistics counters.
module tb_alu_issue_stage;
  import rv32i_types::*;

  localparam int NUM_FWD = 2;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_pc;
  logic [4:0]            in_rs1_idx, in_rs2_idx;
  logic [31:0]           in_rs1_data, in_rs2_data;
  logic [31:0]           in_imm;
  logic                  in_asel, in_bsel;
  alu_ops                in_aluop;
  logic [4:0]            in_rd;
  logic [NUM_FWD-1:0]    fwd_valid;
  logic [NUM_FWD*5-1:0]  fwd_rd;
  logic [NUM_FWD*32-1:0] fwd_data;
  logic                  out_valid;
  logic                  out_ready;
  alu_ops                out_aluop;
  logic [31:0]           out_a, out_b;
  logic [4:0]            out_rd;
  logic [31:0]           out_pc;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]           stat_issued, stat_stall;
`endif

  int n_vec;
  int n_bad;

  alu_issue_stage #(.NUM_FWD(NUM_FWD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_asel(in_asel), .in_bsel(in_bsel),
    .in_aluop(in_aluop), .in_rd(in_rd),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
    .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_pc(out_pc)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; sampling/driving happens 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_pc       = '0;
    in_rs1_idx  = '0;
    in_rs2_idx  = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    in_imm      = '0;
    in_asel     = 1'b0;
    in_bsel     = 1'b0;
    in_aluop    = alu_add;
    in_rd       = '0;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0;
    fwd_rd    = '0;
    fwd_data  = '0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic asel, input logic bsel, input alu_ops op, input logic [4:0] rd);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_rs1_idx  = r1;
    in_rs1_data = d1;
    in_rs2_idx  = r2;
    in_rs2_data = d2;
    in_imm      = imm;
    in_asel     = asel;
    in_bsel     = bsel;
    in_aluop    = op;
    in_rd       = rd;
  endtask

  task automatic set_fwd(input int port, input logic [4:0] rd, input logic [31:0] data);
    fwd_valid[port]       = 1'b1;
    fwd_rd[port*5 +: 5]   = rd;
    fwd_data[port*32 +: 32] = data;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    idle_in();
    clear_fwd();

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_a", out_a, 32'd0);
    check_val("rst_out_b", out_b, 32'd0);

    // Single issue: 7 + imm 3.
    out_ready = 1'b1;
    drive(32'h100, 5'd5, 32'd7, 5'd0, 32'd0, 32'd3, 1'b0, 1'b1, alu_add, 5'd1);
    tick();
    idle_in();
    check_val("single_valid", {31'd0, out_valid}, 32'd1);
    check_val("single_a", out_a, 32'd7);
    check_val("single_b", out_b, 32'd3);
    check_val("single_pc", out_pc, 32'h100);
    check_val("single_rd", {27'd0, out_rd}, 32'd1);
    check_val("single_op", {28'd0, out_aluop}, {28'd0, alu_add});
    tick();
    check_val("single_drained", {31'd0, out_valid}, 32'd0);

    // Back-pressure: A to MAIN, B to SKID, C held upstream.
    out_ready = 1'b0;
    drive(32'h200, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 1'b1, 1'b0, alu_sub, 5'd2);
    tick();
    check_val("bp_a_ready", {31'd0, in_ready}, 32'd1);
    drive(32'h204, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 1'b1, 1'b0, alu_or, 5'd3);
    tick();
    check_val("bp_full_ready", {31'd0, in_ready}, 32'd0);
    drive(32'h208, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 1'b1, 1'b0, alu_and, 5'd4);
    tick();
    check_val("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    check_val("bp_hold_pc", out_pc, 32'h200);
    check_val("bp_hold_a", out_a, 32'h200);
    out_ready = 1'b1;
    tick();
    check_val("bp_b_pc", out_pc, 32'h204);
    check_val("bp_b_rd", {27'd0, out_rd}, 32'd3);
    check_val("bp_b_ready", {31'd0, in_ready}, 32'd1);
    tick();
    idle_in();
    check_val("bp_c_valid", {31'd0, out_valid}, 32'd1);
    check_val("bp_c_pc", out_pc, 32'h208);
    check_val("bp_c_op", {28'd0, out_aluop}, {28'd0, alu_and});
    tick();
    check_val("bp_empty", {31'd0, out_valid}, 32'd0);

    // Forward at capture: port 0 beats port 1.
    out_ready = 1'b0;
    drive(32'h300, 5'd4, 32'h11, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1, alu_add, 5'd5);
    set_fwd(0, 5'd4, 32'h22);
    set_fwd(1, 5'd4, 32'h33);
    tick();
    idle_in();
    clear_fwd();
    check_val("fwd_cap_a", out_a, 32'h22);
    out_ready = 1'b1;
    tick();
    check_val("fwd_cap_drained", {31'd0, out_valid}, 32'd0);

    // Forward while stalled, then an x0 "forward" that must not match.
    out_ready = 1'b0;
    drive(32'h400, 5'd0, 32'd0, 5'd9, 32'd0, 32'd0, 1'b0, 1'b0, alu_xor, 5'd6);
    tick();
    idle_in();
    check_val("stall_b_stale", out_b, 32'd0);
    set_fwd(1, 5'd9, 32'hDEAD);
    tick();
    clear_fwd();
    check_val("stall_b_fwd", out_b, 32'hDEAD);
    tick();
    check_val("stall_b_persist", out_b, 32'hDEAD);
    set_fwd(1, 5'd0, 32'hBEEF);
    tick();
    clear_fwd();
    check_val("stall_x0_a", out_a, 32'd0);
    check_val("stall_x0_b", out_b, 32'hDEAD);

    // Forward into SKID while stalled; seen after it moves to MAIN.
    drive(32'h404, 5'd8, 32'd2, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, alu_add, 5'd7);
    tick();
    idle_in();
    set_fwd(0, 5'd8, 32'h88);
    tick();
    clear_fwd();
    out_ready = 1'b1;
    tick();
    check_val("skid_fwd_pc", out_pc, 32'h404);
    check_val("skid_fwd_a", out_a, 32'h88);
    tick();
    check_val("skid_fwd_drained", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full and an incoming instruction.
    out_ready = 1'b0;
    drive(32'h500, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 1'b0, alu_add, 5'd1);
    tick();
    drive(32'h504, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 1'b0, alu_add, 5'd2);
    tick();
    drive(32'h508, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, 1'b0, alu_add, 5'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    check_val("flush_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check_val("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Reset and flush together.
    drive(32'h600, 5'd3, 32'h77, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, alu_add, 5'd1);
    tick();
    idle_in();
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check_val("rstfl_valid", {31'd0, out_valid}, 32'd0);
    check_val("rstfl_ready", {31'd0, in_ready}, 32'd1);
    check_val("rstfl_a", out_a, 32'd0);

`ifdef ALU_ISSUE_STATS_EN
    // 3 stall cycles then 5 back-to-back issues.
    out_ready = 1'b0;
    drive(32'h700, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, alu_add, 5'd1);
    tick();
    idle_in();
    tick();
    tick();
    tick();
    check_val("stat_stall_3", stat_stall, 32'd3);
    check_val("stat_issued_0", stat_issued, 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      drive(32'h700 + 32'(4 * i), 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, alu_add, 5'd1);
      tick();
    end
    idle_in();
    tick();
    check_val("stat_issued_5", stat_issued, 32'd5);
    check_val("stat_stall_keep", stat_stall, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("stat_flush_issued", stat_issued, 32'd5);
    check_val("stat_flush_stall", stat_stall, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("stat_rst_issued", stat_issued, 32'd0);
    check_val("stat_rst_stall", stat_stall, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
